i2c_slave_regfile: RTL and testbench

Parametrised I2C target with a real SCL/SDA front end: synchronises both pins, detects START, repeated START and STOP, matches a configurable 7-bit address, and serves an internal register file. A pointer byte selects the register, and pointer auto-increment supports burst write and burst read. Sits on the board I2C bus as the next-generation slave; a local host side observes writes and reads registers directly.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_sync_edge.sv | 36 +++
 rtl/i2c_slave_regfile.sv | 193 +++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C target register file.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT
  } i2c_state_e;

  localparam logic I2C_RW_READ = 1'b1;
  localparam logic ACK         = 1'b0;
  localparam logic NACK        = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser for one bus line plus rise/fall detection on the synced level.
module i2c_sync_edge
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic dly_p2;

  // Synchronise the pin and keep one delayed copy; idle bus level is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      dly_p2  <= 1'b1;
    end else begin
      // p0 -> p1: metastability settling
      sync_p0 <= d;
      sync_p1 <= sync_p0;
      // p1 -> p2: edge-detect reference
      dly_p2  <= sync_p1;
    end
  end

  assign q    = sync_p1;
  assign rise = sync_p1 & ~dly_p2;
  assign fall = ~sync_p1 & dly_p2;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with pointer-addressed register file, burst write/read and host-side read port.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         DEPTH      = 16,
  localparam int        PTR_W      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl,
  inout  wire              sda,
  output logic             busy,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_state_e       state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [PTR_W-1:0] ptr;
  logic             sda_oe;
  logic             ack_on;
  logic             rw;

  logic [7:0] mem [DEPTH];
  logic [7:0] ptr_data;
  logic [7:0] next_byte;
  logic       byte_done;
  logic       ptr_ok;
  logic       mem_we;

  i2c_sync_edge u_scl (.clk(clk), .rst(rst), .d(scl), .q(scl_s), .rise(scl_rise), .fall(scl_fall));
  i2c_sync_edge u_sda (.clk(clk), .rst(rst), .d(sda), .q(sda_s), .rise(sda_rise), .fall(sda_fall));

  // Open drain: only ever pull low or release
  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

  assign next_byte = {shreg[6:0], sda_s};
  assign byte_done = scl_rise && (bit_cnt == 3'd7);
  assign ptr_ok    = (next_byte >> PTR_W) == 8'd0;
  assign mem_we    = !start_det && !stop_det && (state == ST_WDATA) && byte_done;

  assign ptr_data = mem[ptr];
  assign rd_data  = mem[rd_addr];

  // Register file: single I2C write port, reads are combinational
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'd0;
    end else if (mem_we) begin
      mem[ptr] <= next_byte;
    end
  end

  // Protocol FSM; bus conditions override any coincident SCL edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= 3'd0;
      shreg    <= 8'd0;
      ptr      <= '0;
      sda_oe   <= 1'b0;
      ack_on   <= 1'b0;
      rw       <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= 8'd0;
    end else begin
      wr_valid <= 1'b0;
      if (stop_det) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        ack_on <= 1'b0;
        busy   <= 1'b0;
      end else if (start_det) begin
        state   <= ST_ADDR;
        sda_oe  <= 1'b0;
        ack_on  <= 1'b0;
        bit_cnt <= 3'd0;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shreg   <= next_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_done) begin
              if (next_byte[7:1] == SLAVE_ADDR) begin
                state <= ST_ADDR_ACK;
                busy  <= 1'b1;
                rw    <= next_byte[0];
              end else begin
                state <= ST_WAIT;
              end
            end
          end
          ST_ADDR_ACK: if (scl_fall) begin
            if (!ack_on) begin
              sda_oe <= 1'b1;
              ack_on <= 1'b1;
            end else begin
              ack_on  <= 1'b0;
              bit_cnt <= 3'd0;
              if (rw == I2C_RW_READ) begin
                state  <= ST_RDATA;
                shreg  <= ptr_data;
                sda_oe <= ~ptr_data[7];
              end else begin
                state  <= ST_PTR;
                sda_oe <= 1'b0;
              end
            end
          end
          ST_PTR: if (scl_rise) begin
            shreg   <= next_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_done) begin
              if (ptr_ok) begin
                ptr   <= next_byte[PTR_W-1:0];
                state <= ST_PTR_ACK;
              end else begin
                state <= ST_WAIT;
              end
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
            if (!ack_on) begin
              sda_oe <= 1'b1;
              ack_on <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              ack_on  <= 1'b0;
              bit_cnt <= 3'd0;
              state   <= ST_WDATA;
            end
          end
          ST_WDATA: if (scl_rise) begin
            shreg   <= next_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_done) begin
              wr_valid <= 1'b1;
              wr_addr  <= ptr;
              wr_data  <= next_byte;
              ptr      <= ptr + PTR_W'(1);
              state    <= ST_WDATA_ACK;
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state  <= ST_RDATA_ACK;
                ack_on <= 1'b0;
              end
            end else if (scl_fall) begin
              shreg  <= {shreg[6:0], 1'b0};
              sda_oe <= ~shreg[6];
            end
          end
          ST_RDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b0;
              end else begin
                ack_on  <= 1'b0;
                bit_cnt <= 3'd0;
                shreg   <= ptr_data;
                sda_oe  <= ~ptr_data[7];
                state   <= ST_RDATA;
              end
            end else if (scl_rise && !ack_on) begin
              ptr <= ptr + PTR_W'(1);
              if (sda_s == ACK) ack_on <= 1'b1;
              else              state  <= ST_WAIT;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: bit-banged master with open-drain bus model.
module tb_i2c_slave_regfile;

  localparam int Q = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  wire        sda;
  logic       busy;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_data;

  int errors = 0;
  int checks = 0;

  logic [3:0] wa_log [32];
  logic [7:0] wd_log [32];
  int         wr_n = 0;
  logic       busy_seen = 1'b0;
  logic       drove = 1'b0;

  assign sda = sda_m ? 1'bz : 1'b0;
  pullup (sda);

  i2c_slave_regfile dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda), .busy(busy),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_valid && wr_n < 32) begin
      wa_log[wr_n] = wr_addr;
      wd_log[wr_n] = wr_data;
      wr_n++;
    end
    if (busy) busy_seen = 1'b1;
    if (sda_m && sda === 1'b0) drove = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    sda_m = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic bit_in(output logic b);
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_in(ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      d[i] = b;
    end
    bit_out(mack);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_rstart;
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb;

    // Reset state
    #23;
    check("rst_sda_released", sda, 1'b1);
    check("rst_busy", busy, 1'b0);
    #30 rst = 1'b1;
    #20;
    check("init_wr_valid", wr_valid, 1'b0);
    check("init_wr_addr", wr_addr, 4'h0);
    check("init_wr_data", wr_data, 8'h00);
    rd_addr = 4'd7; #1;
    check("init_rd_data", rd_data, 8'h00);

    // Burst write: ptr 3, data 0x11, 0x22
    i2c_start;
    send_byte(8'hA0, ack); check("bw_addr_ack", ack, 1'b0);
    check("bw_busy_high", busy, 1'b1);
    send_byte(8'h03, ack); check("bw_ptr_ack", ack, 1'b0);
    send_byte(8'h11, ack); check("bw_d0_ack", ack, 1'b0);
    send_byte(8'h22, ack); check("bw_d1_ack", ack, 1'b0);
    i2c_stop;
    check("bw_busy_low", busy, 1'b0);
    check("bw_wr_count", wr_n, 2);
    check("bw_wr0_addr", wa_log[0], 4'h3);
    check("bw_wr0_data", wd_log[0], 8'h11);
    check("bw_wr1_addr", wa_log[1], 4'h4);
    check("bw_wr1_data", wd_log[1], 8'h22);
    rd_addr = 4'd4; #1; check("bw_rd4", rd_data, 8'h22);
    rd_addr = 4'd3; #1; check("bw_rd3", rd_data, 8'h11);

    // Random read with repeated START
    i2c_start;
    send_byte(8'hA0, ack); check("rr_addr_ack", ack, 1'b0);
    send_byte(8'h03, ack); check("rr_ptr_ack", ack, 1'b0);
    i2c_rstart;
    send_byte(8'hA1, ack); check("rr_raddr_ack", ack, 1'b0);
    recv_byte(1'b0, rb); check("rr_byte0", rb, 8'h11);
    recv_byte(1'b1, rb); check("rr_byte1", rb, 8'h22);
    check("rr_busy_before_stop", busy, 1'b1);
    i2c_stop;
    check("rr_busy_after_stop", busy, 1'b0);
    check("rr_no_writes", wr_n, 2);

    // Address mismatch
    busy_seen = 1'b0; drove = 1'b0;
    i2c_start;
    send_byte(8'hA2, ack); check("mm_addr_nack", ack, 1'b1);
    send_byte(8'h00, ack); check("mm_b0_nack", ack, 1'b1);
    send_byte(8'h5A, ack); check("mm_b1_nack", ack, 1'b1);
    i2c_stop;
    check("mm_sda_never_driven", drove, 1'b0);
    check("mm_busy_never", busy_seen, 1'b0);
    check("mm_no_writes", wr_n, 2);

    // Pointer wrap at DEPTH=16
    i2c_start;
    send_byte(8'hA0, ack); check("wr_addr_ack", ack, 1'b0);
    send_byte(8'h0F, ack); check("wr_ptr_ack", ack, 1'b0);
    send_byte(8'hAA, ack); check("wr_d0_ack", ack, 1'b0);
    send_byte(8'hBB, ack); check("wr_d1_ack", ack, 1'b0);
    send_byte(8'hCC, ack); check("wr_d2_ack", ack, 1'b0);
    i2c_stop;
    check("wrap_wr_count", wr_n, 5);
    check("wrap_wr1_addr", wa_log[3], 4'h0);
    rd_addr = 4'd15; #1; check("wrap_rd15", rd_data, 8'hAA);
    rd_addr = 4'd0;  #1; check("wrap_rd0", rd_data, 8'hBB);
    rd_addr = 4'd1;  #1; check("wrap_rd1", rd_data, 8'hCC);

    // Out-of-range pointer
    i2c_start;
    send_byte(8'hA0, ack); check("bp_addr_ack", ack, 1'b0);
    send_byte(8'h10, ack); check("bp_ptr_nack", ack, 1'b1);
    send_byte(8'h55, ack); check("bp_data_nack", ack, 1'b1);
    i2c_stop;
    check("bp_no_writes", wr_n, 5);
    rd_addr = 4'd0; #1; check("bp_rd0", rd_data, 8'hBB);

    // Reset while the target drives a 0 data bit (bit 7 of 0x11)
    i2c_start;
    send_byte(8'hA0, ack); check("rm_addr_ack", ack, 1'b0);
    send_byte(8'h03, ack); check("rm_ptr_ack", ack, 1'b0);
    i2c_rstart;
    send_byte(8'hA1, ack); check("rm_raddr_ack", ack, 1'b0);
    check("rm_sda_driven_low", sda, 1'b0);
    rst = 1'b0; #1;
    check("rm_sda_released", sda, 1'b1);
    check("rm_busy", busy, 1'b0);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      check("rm_mem_clear", rd_data, 8'h00);
    end
    scl = 1'b1; sda_m = 1'b1;
    #50 rst = 1'b1;
    #200;
    check("rm_busy_idle", busy, 1'b0);
    i2c_start;
    send_byte(8'hA0, ack); check("rm_post_addr_ack", ack, 1'b0);
    send_byte(8'h05, ack); check("rm_post_ptr_ack", ack, 1'b0);
    send_byte(8'h77, ack); check("rm_post_data_ack", ack, 1'b0);
    i2c_stop;
    check("rm_post_wr_count", wr_n, 6);
    check("rm_post_wr_addr", wa_log[5], 4'h5);
    rd_addr = 4'd5; #1; check("rm_post_rd5", rd_data, 8'h77);
    rd_addr = 4'd3; #1; check("rm_post_rd3", rd_data, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
